regfile_scrub: RTL and testbench



---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_scrub_if.sv | 34 +++
 rtl/rf_scoreboard.sv | 59 +++++
 rtl/regfile_scrub.sv | 110 +++++++++++
 tb/tb_regfile_scrub.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the scrubbed register file.
//   rf_state_t   - scrub/run state of the register file controller
//   DEF_DATA_W   - default register width
//   DEF_NUM_REGS - default register count
//   rf_addr_t    - address type for the default register count
package regfile_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] rf_addr_t;

endpackage

// File: rtl/regfile_scrub_if.sv
// regfile_scrub_if: datapath-side bundle of the register file.
//   master - decode/writeback side: drives writeback, issue and read addresses
//   slave  - register file: returns read data, busy bits and init_done
interface regfile_scrub_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) ();

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic              we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              ra_busy;
  logic              rb_busy;
  logic              init_done;

  modport master (
    output we, w_addr, w_data, iss_valid, iss_addr, ra_addr, rb_addr,
    input  ra_data, rb_data, ra_busy, rb_busy, init_done
  );

  modport slave (
    input  we, w_addr, w_data, iss_valid, iss_addr, ra_addr, rb_addr,
    output ra_data, rb_data, ra_busy, rb_busy, init_done
  );

endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for in-flight destinations.
//   clk, rst          - clock, synchronous active-low reset (clears all bits)
//   run               - high once the scrub has finished; updates and reads
//                       are suppressed otherwise
//   we, w_addr        - writeback, clears the busy bit of w_addr
//   iss_valid, iss_addr - issue, sets the busy bit of iss_addr
//   ra_addr, rb_addr  - read addresses
//   ra_busy, rb_busy  - combinational busy of the addressed registers
module rf_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_R0  = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic              ra_busy,
  output logic              rb_busy
);

  logic [NUM_REGS-1:0] busy;

  // A new issue to the same register as a writeback wins: the writeback
  // belongs to the previous producer, the new one is still in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else if (run) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (iss_valid && iss_addr == ADDR_W'(i) && !(ZERO_R0 != 0 && i == 0)) begin
          busy[i] <= 1'b1;
        end else if (we && w_addr == ADDR_W'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // With bypass the reader already sees the writeback data, so the
  // register is no longer a hazard in that cycle.
  logic wb_hit_a, wb_hit_b, zero_a, zero_b;

  always_comb begin
    wb_hit_a = (BYPASS != 0) && we && (w_addr == ra_addr);
    wb_hit_b = (BYPASS != 0) && we && (w_addr == rb_addr);
    zero_a   = (ZERO_R0 != 0) && (ra_addr == '0);
    zero_b   = (ZERO_R0 != 0) && (rb_addr == '0);
    ra_busy  = run && busy[ra_addr] && !wb_hit_a && !zero_a;
    rb_busy  = run && busy[rb_addr] && !wb_hit_b && !zero_b;
  end

endmodule

// File: rtl/regfile_scrub.sv
// regfile_scrub: parametrised 2-read/1-write register file with bypass,
// optional hardwired-zero r0, busy scoreboard and a post-reset scrub that
// zeroes one entry per cycle so the array needs no reset.
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-low
//   bus  - regfile_scrub_if.slave: writeback, issue, two read ports, init_done
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | scrubbing regs[scrub_cnt]; traffic ignored, reads return 0
// RUN   | normal operation; init_done high
module regfile_scrub
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_R0  = 0,
  parameter int BYPASS   = 1
) (
  input  logic     clk,
  input  logic     rst,
  regfile_scrub_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  rf_state_t         state;
  logic [ADDR_W-1:0] scrub_cnt;
  logic              init_done_q;
  logic              run;
  logic              wr_en;
  logic [DATA_W-1:0] regs [NUM_REGS];

  assign run           = (state == RUN);
  assign bus.init_done = init_done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= CLEAR;
      scrub_cnt   <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          scrub_cnt <= scrub_cnt + ADDR_W'(1);
          if (scrub_cnt == ADDR_W'(NUM_REGS - 1)) begin
            state       <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: ;
        default: state <= CLEAR;
      endcase
    end
  end

  assign wr_en = run && bus.we && !(ZERO_R0 != 0 && bus.w_addr == '0);

  // No reset branch on the array itself: contents are defined by the scrub.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == CLEAR) begin
        regs[scrub_cnt] <= '0;
      end else if (wr_en) begin
        regs[bus.w_addr] <= bus.w_data;
      end
    end
  end

  // Read muxes: array, then bypass, then zero-register / not-ready override.
  always_comb begin
    bus.ra_data = regs[bus.ra_addr];
    if (BYPASS != 0 && bus.we && bus.w_addr == bus.ra_addr) begin
      bus.ra_data = bus.w_data;
    end
    if (!run || (ZERO_R0 != 0 && bus.ra_addr == '0)) begin
      bus.ra_data = '0;
    end
  end

  always_comb begin
    bus.rb_data = regs[bus.rb_addr];
    if (BYPASS != 0 && bus.we && bus.w_addr == bus.rb_addr) begin
      bus.rb_data = bus.w_data;
    end
    if (!run || (ZERO_R0 != 0 && bus.rb_addr == '0)) begin
      bus.rb_data = '0;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_R0  (ZERO_R0),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .we        (bus.we),
    .w_addr    (bus.w_addr),
    .iss_valid (bus.iss_valid),
    .iss_addr  (bus.iss_addr),
    .ra_addr   (bus.ra_addr),
    .rb_addr   (bus.rb_addr),
    .ra_busy   (bus.ra_busy),
    .rb_busy   (bus.rb_busy)
  );

endmodule

// File: tb/tb_regfile_scrub.sv
// tb_regfile_scrub: directed bench for regfile_scrub.
//   if0/dut0 - 16x16, BYPASS=1, ZERO_R0=0
//   if1/dut1 - 16x16, BYPASS=0
//   if2/dut2 - 16x16, ZERO_R0=1
//   if3/dut3 - 32x32, own reset (mid-scrub restart)
module tb_regfile_scrub;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst3;

  always #5 clk = ~clk;

  regfile_scrub_if #(.DATA_W(16), .NUM_REGS(16)) if0 ();
  regfile_scrub_if #(.DATA_W(16), .NUM_REGS(16)) if1 ();
  regfile_scrub_if #(.DATA_W(16), .NUM_REGS(16)) if2 ();
  regfile_scrub_if #(.DATA_W(32), .NUM_REGS(32)) if3 ();

  regfile_scrub #(.DATA_W(16), .NUM_REGS(16), .ZERO_R0(0), .BYPASS(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  regfile_scrub #(.DATA_W(16), .NUM_REGS(16), .ZERO_R0(0), .BYPASS(0))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  regfile_scrub #(.DATA_W(16), .NUM_REGS(16), .ZERO_R0(1), .BYPASS(1))
    dut2 (.clk(clk), .rst(rst), .bus(if2));
  regfile_scrub #(.DATA_W(32), .NUM_REGS(32), .ZERO_R0(0), .BYPASS(1))
    dut3 (.clk(clk), .rst(rst3), .bus(if3));

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    rf_addr_t    wa;
    logic [15:0] wd;
    logic        iss;
    rf_addr_t    ia;
    rf_addr_t    ra;
    rf_addr_t    rb;
    logic [15:0] e_ra;
    logic [15:0] e_rb;
    logic        e_rab;
    logic        e_rbb;
  } vec_t;

  vec_t vecs [10];

  task automatic idle_all();
    if0.we = 0; if0.w_addr = 0; if0.w_data = 0; if0.iss_valid = 0; if0.iss_addr = 0;
    if0.ra_addr = 0; if0.rb_addr = 0;
    if1.we = 0; if1.w_addr = 0; if1.w_data = 0; if1.iss_valid = 0; if1.iss_addr = 0;
    if1.ra_addr = 0; if1.rb_addr = 0;
    if2.we = 0; if2.w_addr = 0; if2.w_data = 0; if2.iss_valid = 0; if2.iss_addr = 0;
    if2.ra_addr = 0; if2.rb_addr = 0;
    if3.we = 0; if3.w_addr = 0; if3.w_data = 0; if3.iss_valid = 0; if3.iss_addr = 0;
    if3.ra_addr = 0; if3.rb_addr = 0;
  endtask

  initial begin
    int low;

    //          we  wa  wd        iss ia  ra  rb  e_ra      e_rb      rab  rbb
    vecs[0] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd9, 4'd7, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd9, 4'd7, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 4'd7, 16'h0777, 1'b0, 4'd0, 4'd9, 4'd7, 16'h0000, 16'h0777, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd9, 4'd7, 16'h0000, 16'h0777, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'd9, 16'h0999, 1'b1, 4'd9, 4'd9, 4'd7, 16'h0999, 16'h0777, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd9, 4'd7, 16'h0999, 16'h0777, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 4'd9, 16'h9999, 1'b0, 4'd0, 4'd9, 4'd5, 16'h9999, 16'hBEEF, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd9, 4'd5, 16'h9999, 16'hBEEF, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 4'd3, 16'h0333, 1'b1, 4'd2, 4'd2, 4'd3, 16'h0000, 16'h0333, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd2, 4'd3, 16'h0000, 16'h0333, 1'b1, 1'b0};

    rst  = 1'b0;
    rst3 = 1'b0;
    idle_all();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_init_done", if0.init_done, 1'b0);
    chk("reset_ra_data", if0.ra_data, 16'h0);
    chk("reset_ra_busy", if0.ra_busy, 1'b0);
    chk("reset_init_done3", if3.init_done, 1'b0);

    // First scrub
    @(posedge clk); #1;
    rst = 1'b1;
    low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if0.init_done) break;
      low++;
    end
    chk("first_scrub_cycles", low, 16);

    // Fill every entry with a known pattern
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if0.we = 1'b1; if0.w_addr = 4'(i); if0.w_data = 16'hA500 + 16'(i);
    end
    @(posedge clk); #1;
    if0.we = 1'b0; if0.ra_addr = 4'd3;
    @(negedge clk);
    chk("fill_r3", if0.ra_data, 16'hA503);

    // Drop rst for one cycle, then scrub with traffic that must be ignored
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    if0.we = 1'b1; if0.w_addr = 4'd3; if0.w_data = 16'hDEAD;
    if0.iss_valid = 1'b1; if0.iss_addr = 4'd3;
    if0.ra_addr = 4'd3; if0.rb_addr = 4'd3;
    low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if0.init_done) break;
      if (k == 4) begin
        chk("clear_ra_data", if0.ra_data, 16'h0);
        chk("clear_rb_busy", if0.rb_busy, 1'b0);
      end
      low++;
    end
    if0.we = 1'b0; if0.iss_valid = 1'b0;
    chk("scrub_cycles", low, 16);

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if0.ra_addr = 4'(i);
      @(negedge clk);
      chk($sformatf("scrubbed_r%0d", i), if0.ra_data, 16'h0);
    end
    chk("r3_not_busy", if0.rb_busy, 1'b0);

    // Bypass vs. no bypass
    @(posedge clk); #1;
    if0.we = 1'b1; if0.w_addr = 4'd5; if0.w_data = 16'hBEEF; if0.ra_addr = 4'd5;
    if1.we = 1'b1; if1.w_addr = 4'd5; if1.w_data = 16'hBEEF; if1.ra_addr = 4'd5;
    @(negedge clk);
    chk("bypass_same_cycle", if0.ra_data, 16'hBEEF);
    chk("nobypass_old_value", if1.ra_data, 16'h0);
    @(posedge clk); #1;
    if0.we = 1'b0; if1.we = 1'b0;
    @(negedge clk);
    chk("array_next_cycle", if0.ra_data, 16'hBEEF);
    chk("nobypass_next_cycle", if1.ra_data, 16'hBEEF);

    // Hardwired zero register
    @(posedge clk); #1;
    if2.we = 1'b1; if2.w_addr = 4'd0; if2.w_data = 16'h1234;
    if2.iss_valid = 1'b1; if2.iss_addr = 4'd0; if2.ra_addr = 4'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("zero_data_c%0d", c), if2.ra_data, 16'h0);
      chk($sformatf("zero_busy_c%0d", c), if2.ra_busy, 1'b0);
      @(posedge clk); #1;
    end
    if2.we = 1'b0; if2.iss_valid = 1'b0;
    @(negedge clk);
    chk("zero_data_after", if2.ra_data, 16'h0);
    chk("zero_busy_after", if2.ra_busy, 1'b0);

    // Scoreboard / bypass vector table
    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      if0.we = vecs[v].we; if0.w_addr = vecs[v].wa; if0.w_data = vecs[v].wd;
      if0.iss_valid = vecs[v].iss; if0.iss_addr = vecs[v].ia;
      if0.ra_addr = vecs[v].ra; if0.rb_addr = vecs[v].rb;
      @(negedge clk);
      chk($sformatf("v%0d_ra_data", v), if0.ra_data, vecs[v].e_ra);
      chk($sformatf("v%0d_rb_data", v), if0.rb_data, vecs[v].e_rb);
      chk($sformatf("v%0d_ra_busy", v), if0.ra_busy, vecs[v].e_rab);
      chk($sformatf("v%0d_rb_busy", v), if0.rb_busy, vecs[v].e_rbb);
    end
    @(posedge clk); #1;
    if0.we = 1'b0; if0.iss_valid = 1'b0;

    // 32x32 instance: abort scrub at counter 9, then full restart
    rst3 = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    rst3 = 1'b0;
    @(negedge clk);
    chk("abort_init_done", if3.init_done, 1'b0);
    @(posedge clk); #1;
    rst3 = 1'b1;
    low = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (if3.init_done) break;
      low++;
    end
    chk("restart_scrub_cycles", low, 32);

    @(posedge clk); #1;
    if3.we = 1'b1; if3.w_addr = 5'd31; if3.w_data = 32'hFFFF_FFFF;
    if3.ra_addr = 5'd31; if3.rb_addr = 5'd30;
    @(negedge clk);
    chk("w32_bypass", if3.ra_data, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    if3.we = 1'b0;
    @(negedge clk);
    chk("w32_r31", if3.ra_data, 32'hFFFF_FFFF);
    chk("w32_r30", if3.rb_data, 32'h0);
    chk("w32_r31_busy", if3.ra_busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
